crc_check_rx: RTL and testbench
===============================

Name: crc_check_rx

Overview:
- Serial CRC checker; sits directly downstream of the serial CRC encoder.
- Consumes the MSB-first codeword bit stream: DATA_BITS data bits followed by CRC_BITS check bits.
- Recomputes the remainder over the whole codeword and recovers the data word.
- Reports the data word with a pass/fail flag to the frame consumer.

Parameters:
- DATA_BITS, 4, data bits per codeword.
- CRC_BITS, 3, CRC width; generator degree.
- POLY, 3'b011, generator low-order coefficients; the x^CRC_BITS term is implicit. Default is x^3+x+1.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  i_bit is meaningful this cycle.
- i_sof  in  1  start of frame; qualified by i_valid; marks codeword bit 0.
- i_bit  in  1  serial codeword bit, MSB first.
- o_data  out  DATA_BITS  recovered data word; held until the next frame completes.
- o_frame_valid  out  1  one-cycle pulse when a frame completes.
- o_crc_err  out  1  remainder non-zero for the last completed frame; held.
- o_busy  out  1  high while in RECV.

Behaviour:
- Reset, asynchronous on i_rst high:
  - state=IDLE; remainder, bit counter and data shift register cleared.
  - o_data=0, o_frame_valid=0, o_crc_err=0, o_busy=0.
- Frame length N = DATA_BITS + CRC_BITS. Bit counter width is $clog2(N).
- Accepted bit: i_valid=1 and either (state=RECV) or (i_sof=1).
- On each accepted bit:
  - fb = rem[CRC_BITS-1]
  - rem <= {rem[CRC_BITS-2:0], i_bit} ^ (fb ? POLY : 0)
  - Data shift register shifts i_bit in LSB-side while count < DATA_BITS.
  - On a sof bit, rem and count restart from zero before that bit is applied.
- State machine:
  - IDLE: i_valid & i_sof -> RECV, count=1. i_valid without i_sof is ignored. o_busy=0.
  - RECV: i_valid=0 stalls; no state change, no timeout.
  - RECV: accepted bit with count=N-1 -> IDLE, frame complete.
  - RECV: any other accepted bit -> count+1.
- Completion output, registered; one cycle after the edge that accepts the last bit:
  - o_frame_valid=1 for exactly one cycle.
  - o_data = first DATA_BITS bits received; first bit lands in the MSB.
  - o_crc_err = (final rem != 0).
- Boundary cases:
  - i_sof accepted mid-frame in RECV: current frame is aborted silently with no pulse and o_crc_err unchanged. The sof bit starts a new frame with count=1.
  - i_sof on the last-bit position: the sof wins, and the partial frame is aborted.
  - Back-to-back frames: i_sof on the cycle after the last bit is accepted normally. o_frame_valid for the old frame pulses in that same cycle.
  - Reset mid-frame: all state cleared, no pulse, the partial frame is lost.
  - i_bit and i_sof are ignored when i_valid=0.

Optional Feature:
- Macro: CRC_CHECK_STATS_EN.
- Defined:
  - Adds port o_err_cnt, out, 8 bits, reset 0.
  - Increments on each o_frame_valid pulse with o_crc_err=1.
  - Saturates at 8'hFF.
  - Aborted frames are not counted.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then send 1001110 (sof on the first bit, valid continuous) -> o_frame_valid pulse 1 cycle after bit 7; o_data=4'b1001, o_crc_err=0.
- Send 1101001 -> o_data=4'b1101, o_crc_err=0. Then send 1101011 (flipped bit) -> o_data=4'b1101, o_crc_err=1, and the flag holds afterwards.
- Send 1001110 with i_valid deasserted for 3 cycles after bit 4 -> stall with o_busy=1; result identical to test 1, pulse delayed by 3 cycles.
- Send 3 bits, then i_sof with a new frame 1101001 -> no pulse for the aborted frame; a single pulse with o_data=4'b1101, o_crc_err=0.
- Back-to-back 1001110 then 1101001 with no gap -> two pulses 7 cycles apart with the correct data. Separately: assert i_rst mid-frame -> all outputs 0 and no pulse; the next frame decodes normally.
- Build with CRC_CHECK_STATS_EN: 300 corrupted frames -> o_err_cnt=8'hFF; good and aborted frames leave it unchanged.

Source files
------------

// File: rtl/crc_check_rx.sv
// rtl/crc_check_rx.sv - serial MSB-first CRC checker that recovers the data word and flags remainder errors
// Optional error counter output o_err_cnt is built when CRC_CHECK_STATS_EN is defined.
module crc_check_rx #(
   parameter int                  DATA_BITS = 4,
   parameter int                  CRC_BITS  = 3,
   parameter logic [CRC_BITS-1:0] POLY      = 3'b011
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_valid,
   input  logic                 i_sof,
   input  logic                 i_bit,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_frame_valid,
   output logic                 o_crc_err,
`ifdef CRC_CHECK_STATS_EN
   output logic [7:0]           o_err_cnt,
`endif
   output logic                 o_busy
);

   localparam int N     = DATA_BITS + CRC_BITS;
   localparam int CNT_W = $clog2(N);
   localparam logic [CNT_W-1:0] LAST_C      = CNT_W'(N - 1);
   localparam logic [CNT_W-1:0] DATA_BITS_C = CNT_W'(DATA_BITS);

   typedef enum logic {IDLE, RECV} state_t;

   state_t               state_q, state_d;
   logic [CRC_BITS-1:0]  rem_q, rem_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic [DATA_BITS-1:0] o_data_q, o_data_d;
   logic                 o_frame_valid_q, o_frame_valid_d;
   logic                 o_crc_err_q, o_crc_err_d;

   logic                 accept;
   logic [CRC_BITS-1:0]  rem_base, rem_next;
   logic [CNT_W-1:0]     count_base;
   logic [DATA_BITS-1:0] data_base, data_next;

`ifdef CRC_CHECK_STATS_EN
   logic [7:0]           err_cnt_q, err_cnt_d;
`endif

   always_comb begin
      state_d         = state_q;
      rem_d           = rem_q;
      count_d         = count_q;
      data_d          = data_q;
      o_data_d        = o_data_q;
      o_frame_valid_d = 1'b0;
      o_crc_err_d     = o_crc_err_q;

      accept = i_valid && ((state_q == RECV) || i_sof);

      // A sof bit restarts the frame: it is applied on top of cleared state.
      rem_base   = i_sof ? '0 : rem_q;
      count_base = i_sof ? '0 : count_q;
      data_base  = i_sof ? '0 : data_q;

      rem_next  = {rem_base[CRC_BITS-2:0], i_bit} ^ (rem_base[CRC_BITS-1] ? POLY : '0);
      data_next = (count_base < DATA_BITS_C) ? {data_base[DATA_BITS-2:0], i_bit} : data_base;

      if (accept) begin
         rem_d  = rem_next;
         data_d = data_next;
         if (!i_sof && (count_q == LAST_C)) begin
            state_d         = IDLE;
            count_d         = '0;
            o_frame_valid_d = 1'b1;
            o_data_d        = data_next;
            o_crc_err_d     = |rem_next;
         end else begin
            state_d = RECV;
            count_d = count_base + 1'b1;
         end
      end
   end

`ifdef CRC_CHECK_STATS_EN
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (o_frame_valid_d && o_crc_err_d && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign o_err_cnt = err_cnt_q;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q         <= IDLE;
         rem_q           <= '0;
         count_q         <= '0;
         data_q          <= '0;
         o_data_q        <= '0;
         o_frame_valid_q <= 1'b0;
         o_crc_err_q     <= 1'b0;
      end else begin
         state_q         <= state_d;
         rem_q           <= rem_d;
         count_q         <= count_d;
         data_q          <= data_d;
         o_data_q        <= o_data_d;
         o_frame_valid_q <= o_frame_valid_d;
         o_crc_err_q     <= o_crc_err_d;
      end
   end

   assign o_data        = o_data_q;
   assign o_frame_valid = o_frame_valid_q;
   assign o_crc_err     = o_crc_err_q;
   assign o_busy        = (state_q == RECV);

endmodule

// File: tb/tb_crc_check_rx.sv
// tb/tb_crc_check_rx.sv - directed table-driven bench for crc_check_rx (x^3+x+1, 4 data bits)
module tb_crc_check_rx;

   logic       i_clk = 1'b0;
   logic       i_rst;
   logic       i_valid;
   logic       i_sof;
   logic       i_bit;
   logic [3:0] o_data;
   logic       o_frame_valid;
   logic       o_crc_err;
   logic       o_busy;
`ifdef CRC_CHECK_STATS_EN
   logic [7:0] o_err_cnt;
`endif

   crc_check_rx dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_valid       (i_valid),
      .i_sof         (i_sof),
      .i_bit         (i_bit),
      .o_data        (o_data),
      .o_frame_valid (o_frame_valid),
      .o_crc_err     (o_crc_err),
`ifdef CRC_CHECK_STATS_EN
      .o_err_cnt     (o_err_cnt),
`endif
      .o_busy        (o_busy)
   );

   always #5 i_clk = ~i_clk;

   int n_vec  = 0;
   int n_fail = 0;
   int cyc    = 0;

   int         pulse_cyc[$];
   logic [3:0] pulse_data[$];
   logic       pulse_err[$];

   always @(posedge i_clk) cyc <= cyc + 1;

   always @(negedge i_clk) begin
      if (o_frame_valid === 1'b1) begin
         pulse_cyc.push_back(cyc);
         pulse_data.push_back(o_data);
         pulse_err.push_back(o_crc_err);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_pulses();
      pulse_cyc.delete();
      pulse_data.delete();
      pulse_err.delete();
   endtask

   task automatic step(input logic v, input logic s, input logic b);
      i_valid = v;
      i_sof   = s;
      i_bit   = b;
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic send_bits(input logic [6:0] cw, input int nbits);
      for (int i = 0; i < nbits; i++) step(1'b1, (i == 0), cw[6-i]);
   endtask

   typedef struct {
      logic [6:0] cw;
      int         stall_after;
      int         stall_len;
      logic [3:0] exp_data;
      logic       exp_err;
   } vec_t;

   vec_t vecs[7];

   initial begin
      vecs[0] = '{7'b1001110, 0, 0, 4'b1001, 1'b0};
      vecs[1] = '{7'b1101001, 0, 0, 4'b1101, 1'b0};
      vecs[2] = '{7'b1101011, 0, 0, 4'b1101, 1'b1};
      vecs[3] = '{7'b1001110, 4, 3, 4'b1001, 1'b0};
      vecs[4] = '{7'b1111111, 2, 1, 4'b1111, 1'b0};
      vecs[5] = '{7'b0000000, 0, 0, 4'b0000, 1'b0};
      vecs[6] = '{7'b0000001, 0, 0, 4'b0000, 1'b1};

      i_rst   = 1'b1;
      i_valid = 1'b0;
      i_sof   = 1'b0;
      i_bit   = 1'b0;
      idle(2);
      chk("reset o_data", o_data, 4'b0);
      chk("reset o_frame_valid", o_frame_valid, 1'b0);
      chk("reset o_crc_err", o_crc_err, 1'b0);
      chk("reset o_busy", o_busy, 1'b0);
      i_rst = 1'b0;
      idle(1);

      // valid without sof in IDLE is ignored
      step(1'b1, 1'b0, 1'b1);
      chk("idle no-sof busy", o_busy, 1'b0);

      for (int v = 0; v < 7; v++) begin
         for (int i = 0; i < 7; i++) begin
            step(1'b1, (i == 0), vecs[v].cw[6-i]);
            if (vecs[v].stall_len > 0 && i + 1 == vecs[v].stall_after) begin
               for (int k = 0; k < vecs[v].stall_len; k++) begin
                  step(1'b0, 1'b1, k[0]);
                  chk($sformatf("v%0d stall busy", v), o_busy, 1'b1);
                  chk($sformatf("v%0d stall no pulse", v), o_frame_valid, 1'b0);
               end
            end
         end
         chk($sformatf("v%0d pulse", v), o_frame_valid, 1'b1);
         chk($sformatf("v%0d data", v), o_data, vecs[v].exp_data);
         chk($sformatf("v%0d crc_err", v), o_crc_err, vecs[v].exp_err);
         idle(1);
         chk($sformatf("v%0d pulse width", v), o_frame_valid, 1'b0);
         chk($sformatf("v%0d err held", v), o_crc_err, vecs[v].exp_err);
         chk($sformatf("v%0d busy after", v), o_busy, 1'b0);
      end

      // sof mid-frame: abort silently, error flag untouched until new frame completes
      clear_pulses();
      send_bits(7'b1001110, 3);
      step(1'b1, 1'b1, 1'b1);
      chk("abort err unchanged", o_crc_err, 1'b1);
      for (int i = 1; i < 7; i++) step(1'b1, 1'b0, 7'b1101001 >> (6 - i));
      idle(2);
      chk("abort pulse count", pulse_cyc.size(), 1);
      if (pulse_cyc.size() == 1) begin
         chk("abort data", pulse_data[0], 4'b1101);
         chk("abort err", pulse_err[0], 1'b0);
      end

      // sof on last-bit position wins
      clear_pulses();
      send_bits(7'b1001110, 6);
      send_bits(7'b1101001, 7);
      idle(2);
      chk("lastpos pulse count", pulse_cyc.size(), 1);
      if (pulse_cyc.size() == 1) chk("lastpos data", pulse_data[0], 4'b1101);

      // back-to-back frames
      clear_pulses();
      send_bits(7'b1001110, 7);
      send_bits(7'b1101001, 7);
      idle(2);
      chk("b2b pulse count", pulse_cyc.size(), 2);
      if (pulse_cyc.size() == 2) begin
         chk("b2b spacing", pulse_cyc[1] - pulse_cyc[0], 7);
         chk("b2b data0", pulse_data[0], 4'b1001);
         chk("b2b data1", pulse_data[1], 4'b1101);
         chk("b2b err1", pulse_err[1], 1'b0);
      end

      // reset mid-frame (o_data is 1101 beforehand)
      send_bits(7'b1101011, 7);
      idle(1);
      clear_pulses();
      send_bits(7'b1001110, 3);
      i_rst = 1'b1;
      #1;
      chk("rst data", o_data, 4'b0);
      chk("rst err", o_crc_err, 1'b0);
      chk("rst busy", o_busy, 1'b0);
      chk("rst valid", o_frame_valid, 1'b0);
      idle(2);
      i_rst = 1'b0;
      idle(1);
      chk("rst no pulse", pulse_cyc.size(), 0);
      send_bits(7'b1001110, 7);
      idle(1);
      chk("post-rst pulse count", pulse_cyc.size(), 1);
      if (pulse_cyc.size() == 1) chk("post-rst data", pulse_data[0], 4'b1001);

`ifdef CRC_CHECK_STATS_EN
      i_rst = 1'b1;
      idle(1);
      i_rst = 1'b0;
      chk("stats reset", o_err_cnt, 8'd0);
      repeat (5) send_bits(7'b1001111, 7);
      idle(1);
      chk("stats 5 bad", o_err_cnt, 8'd5);
      send_bits(7'b1001110, 7);
      idle(1);
      chk("stats good frame", o_err_cnt, 8'd5);
      send_bits(7'b1001111, 5);
      send_bits(7'b1101001, 7);
      idle(1);
      chk("stats aborted", o_err_cnt, 8'd5);
      repeat (300) send_bits(7'b1001111, 7);
      idle(1);
      chk("stats saturate", o_err_cnt, 8'hFF);
      send_bits(7'b1101001, 7);
      idle(1);
      chk("stats sat good", o_err_cnt, 8'hFF);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
